pkt_rx_checker: RTL and testbench

PKT_RX_CHECKER -- requirements
Module: pkt_rx_checker

---
 rtl/pkt_rx_checker_if.sv | 24 ++
 rtl/pkt_rx_checker.sv | 150 +++++++++++++++
 tb/tb_pkt_rx_checker.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_rx_checker_if.sv
// MAC RX FIFO read port: packet-available flag, word bus with framing, read enable back.
// Master is the MAC FIFO side; slave is the checker that pulls words with pkt_rx_ren.
interface pkt_rx_checker_if;
    logic        pkt_rx_avail;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_val;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic        pkt_rx_err;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_ren;

    modport master (
        output pkt_rx_avail, pkt_rx_data, pkt_rx_val, pkt_rx_sop,
               pkt_rx_eop, pkt_rx_err, pkt_rx_mod,
        input  pkt_rx_ren
    );

    modport slave (
        input  pkt_rx_avail, pkt_rx_data, pkt_rx_val, pkt_rx_sop,
               pkt_rx_eop, pkt_rx_err, pkt_rx_mod,
        output pkt_rx_ren
    );
endinterface

// File: rtl/pkt_rx_checker.sv
// Drains MAC RX packets, checks incrementing payload, framing, length and MAC error, keeps stats.
// Counters and pkt_done update one cycle after the eop word; no backpressure beyond ren (drops only at eop).
module pkt_rx_checker (
    input  logic            clk_156,
    input  logic            reset_156m25,
    input  logic            chk_enable,
    input  logic            cnt_clear,
    input  logic [13:0]     cfg_max_len,
    pkt_rx_checker_if.slave rx,
    output logic [31:0]     pkt_cnt,
    output logic [31:0]     data_err_cnt,
    output logic [31:0]     frame_err_cnt,
    output logic [31:0]     len_err_cnt,
    output logic [31:0]     mac_err_cnt,
    output logic [47:0]     byte_cnt,
    output logic            pkt_done,
    output logic            busy
);
    typedef enum logic {R_IDLE, R_READ} rd_state_t;
    typedef enum logic {F_OUT, F_IN} fr_state_t;

    rd_state_t   rd_state, rd_next;
    fr_state_t   fr_state, fr_next;

    logic [63:0] exp_word;
    logic [10:0] wcnt;
    logic        data_bad_r;

    logic        frame_err_inc;
    logic        pkt_end;
    logic        word_bad;
    logic        pkt_data_bad;
    logic        len_bad;
    logic [10:0] words;
    logic [14:0] pkt_len;
    logic [63:0] cmp_mask;
    logic [48:0] byte_sum;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk_156) begin
        if (reset_156m25) rd_state <= R_IDLE;
        else              rd_state <= rd_next;
    end

    // ren only falls after an eop word, so a packet is never cut short mid-read
    always_comb begin
        rd_next       = rd_state;
        rx.pkt_rx_ren = 1'b0;
        busy          = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (chk_enable && rx.pkt_rx_avail) rd_next = R_READ;
            end
            R_READ: begin
                rx.pkt_rx_ren = 1'b1;
                busy          = 1'b1;
                if (rx.pkt_rx_val && rx.pkt_rx_eop && (!rx.pkt_rx_avail || !chk_enable))
                    rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        fr_next       = fr_state;
        frame_err_inc = 1'b0;
        pkt_end       = 1'b0;
        word_bad      = 1'b0;
        words         = wcnt;
        cmp_mask      = (rx.pkt_rx_mod == 3'd0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                               : ~(64'hFFFF_FFFF_FFFF_FFFF >> {rx.pkt_rx_mod, 3'b000});
        if (rx.pkt_rx_val) begin
            if (rx.pkt_rx_sop) begin
                frame_err_inc = (fr_state == F_IN);
                fr_next       = rx.pkt_rx_eop ? F_OUT : F_IN;
                pkt_end       = rx.pkt_rx_eop;
                words         = 11'd1;
            end else if (fr_state == F_IN) begin
                word_bad = |((rx.pkt_rx_data ^ exp_word) &
                             (rx.pkt_rx_eop ? cmp_mask : 64'hFFFF_FFFF_FFFF_FFFF));
                words    = (wcnt == 11'h7FF) ? wcnt : wcnt + 11'd1;
                pkt_end  = rx.pkt_rx_eop;
                if (rx.pkt_rx_eop) fr_next = F_OUT;
            end else begin
                frame_err_inc = 1'b1;
            end
        end
        pkt_data_bad = word_bad | (rx.pkt_rx_sop ? 1'b0 : data_bad_r);
        pkt_len      = {1'b0, words - 11'd1, 3'b000} +
                       ((rx.pkt_rx_mod == 3'd0) ? 15'd8 : {12'd0, rx.pkt_rx_mod});
        // a saturated word counter means the true length is unknown, so flag it
        len_bad      = (pkt_len < 15'd64) || (pkt_len > {1'b0, cfg_max_len}) || (words == 11'h7FF);
        byte_sum     = {1'b0, byte_cnt} + {34'd0, pkt_len};
    end

    always_ff @(posedge clk_156) begin
        if (reset_156m25) begin
            fr_state   <= F_OUT;
            exp_word   <= 64'd0;
            wcnt       <= 11'd0;
            data_bad_r <= 1'b0;
        end else begin
            fr_state <= fr_next;
            if (rx.pkt_rx_val) begin
                if (rx.pkt_rx_sop) begin
                    exp_word   <= rx.pkt_rx_data + 64'd1;
                    wcnt       <= 11'd1;
                    data_bad_r <= 1'b0;
                end else if (fr_state == F_IN) begin
                    exp_word   <= exp_word + 64'd1;
                    wcnt       <= words;
                    data_bad_r <= data_bad_r | word_bad;
                end
            end
        end
    end

    always_ff @(posedge clk_156) begin
        if (reset_156m25) begin
            pkt_done      <= 1'b0;
            pkt_cnt       <= 32'd0;
            data_err_cnt  <= 32'd0;
            frame_err_cnt <= 32'd0;
            len_err_cnt   <= 32'd0;
            mac_err_cnt   <= 32'd0;
            byte_cnt      <= 48'd0;
        end else begin
            pkt_done <= pkt_end;
            if (cnt_clear) begin
                pkt_cnt       <= 32'd0;
                data_err_cnt  <= 32'd0;
                frame_err_cnt <= 32'd0;
                len_err_cnt   <= 32'd0;
                mac_err_cnt   <= 32'd0;
                byte_cnt      <= 48'd0;
            end else begin
                pkt_cnt       <= sat_inc(pkt_cnt, pkt_end);
                data_err_cnt  <= sat_inc(data_err_cnt, pkt_end && pkt_data_bad);
                frame_err_cnt <= sat_inc(frame_err_cnt, frame_err_inc);
                len_err_cnt   <= sat_inc(len_err_cnt, pkt_end && len_bad);
                mac_err_cnt   <= sat_inc(mac_err_cnt, pkt_end && rx.pkt_rx_err);
                if (pkt_end)
                    byte_cnt <= byte_sum[48] ? 48'hFFFF_FFFF_FFFF : byte_sum[47:0];
            end
        end
    end
endmodule

// File: tb/tb_pkt_rx_checker.sv
// Bench for pkt_rx_checker: directed literal cases plus randomized packets against a packet-level model.
module tb_pkt_rx_checker;
    logic        clk_156 = 1'b0;
    logic        reset_156m25;
    logic        chk_enable;
    logic        cnt_clear;
    logic [13:0] cfg_max_len;
    logic [31:0] pkt_cnt, data_err_cnt, frame_err_cnt, len_err_cnt, mac_err_cnt;
    logic [47:0] byte_cnt;
    logic        pkt_done, busy;

    pkt_rx_checker_if rx();

    pkt_rx_checker dut (
        .clk_156      (clk_156),
        .reset_156m25 (reset_156m25),
        .chk_enable   (chk_enable),
        .cnt_clear    (cnt_clear),
        .cfg_max_len  (cfg_max_len),
        .rx           (rx),
        .pkt_cnt      (pkt_cnt),
        .data_err_cnt (data_err_cnt),
        .frame_err_cnt(frame_err_cnt),
        .len_err_cnt  (len_err_cnt),
        .mac_err_cnt  (mac_err_cnt),
        .byte_cnt     (byte_cnt),
        .pkt_done     (pkt_done),
        .busy         (busy)
    );

    always #3 clk_156 = ~clk_156;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Packet-level model: collect the whole packet, judge it at eop.
    bit          m_in;
    bit          m_read;
    logic [63:0] m_words[$];
    logic [31:0] e_pkt, e_derr, e_ferr, e_lerr, e_merr;
    logic [47:0] e_bytes;
    bit          e_done;

    function automatic logic [31:0] sadd(input logic [31:0] v, input bit inc);
        return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    function automatic void model_step();
        int n, nw, len, m;
        bit fin, ferr, dbad, lbad;
        logic [63:0] mask;
        logic [48:0] bsum;
        if (reset_156m25) begin
            m_in = 0; m_read = 0; m_words.delete(); e_done = 0;
            e_pkt = 0; e_derr = 0; e_ferr = 0; e_lerr = 0; e_merr = 0; e_bytes = 0;
            return;
        end
        if (!m_read) m_read = chk_enable && rx.pkt_rx_avail;
        else if (rx.pkt_rx_val && rx.pkt_rx_eop && !(rx.pkt_rx_avail && chk_enable)) m_read = 0;

        fin = 0; ferr = 0; dbad = 0; lbad = 0; len = 0;
        if (rx.pkt_rx_val) begin
            if (rx.pkt_rx_sop) begin
                ferr = m_in;
                m_words.delete();
                m_words.push_back(rx.pkt_rx_data);
                m_in = 1;
            end else if (m_in) begin
                m_words.push_back(rx.pkt_rx_data);
            end else begin
                ferr = 1;
            end
            if (rx.pkt_rx_eop && m_in) begin
                fin = 1;
                m_in = 0;
            end
        end
        if (fin) begin
            n  = m_words.size();
            nw = (n > 2047) ? 2047 : n;
            m  = int'(rx.pkt_rx_mod);
            len = 8 * (nw - 1) + ((m == 0) ? 8 : m);
            lbad = (len < 64) || (len > int'(cfg_max_len)) || (n >= 2047);
            for (int i = 0; i < n; i++) begin
                mask = 64'hFFFF_FFFF_FFFF_FFFF;
                if (i == n - 1 && m != 0) mask = mask << (64 - 8 * m);
                if (((m_words[i] ^ (m_words[0] + 64'(i))) & mask) != 64'd0) dbad = 1;
            end
        end
        e_done = fin;
        if (cnt_clear) begin
            e_pkt = 0; e_derr = 0; e_ferr = 0; e_lerr = 0; e_merr = 0; e_bytes = 0;
        end else begin
            e_pkt  = sadd(e_pkt, fin);
            e_derr = sadd(e_derr, fin && dbad);
            e_ferr = sadd(e_ferr, ferr);
            e_lerr = sadd(e_lerr, fin && lbad);
            e_merr = sadd(e_merr, fin && rx.pkt_rx_err);
            bsum = {1'b0, e_bytes} + 49'(len);
            if (fin) e_bytes = bsum[48] ? 48'hFFFF_FFFF_FFFF : bsum[47:0];
        end
    endfunction

    always @(negedge clk_156) begin
        check("pkt_cnt", 64'(pkt_cnt), 64'(e_pkt));
        check("data_err_cnt", 64'(data_err_cnt), 64'(e_derr));
        check("frame_err_cnt", 64'(frame_err_cnt), 64'(e_ferr));
        check("len_err_cnt", 64'(len_err_cnt), 64'(e_lerr));
        check("mac_err_cnt", 64'(mac_err_cnt), 64'(e_merr));
        check("byte_cnt", 64'(byte_cnt), 64'(e_bytes));
        check("pkt_done", 64'(pkt_done), 64'(e_done));
        check("pkt_rx_ren", 64'(rx.pkt_rx_ren), 64'(m_read));
        check("busy", 64'(busy), 64'(m_read));
    end

    task automatic cyc();
        model_step();
        @(negedge clk_156);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            rx.pkt_rx_val = 0; rx.pkt_rx_sop = 0; rx.pkt_rx_eop = 0; rx.pkt_rx_err = 0;
            cyc();
        end
    endtask

    task automatic word(bit s, bit e, logic [2:0] m, bit er, logic [63:0] d);
        rx.pkt_rx_val = 1; rx.pkt_rx_sop = s; rx.pkt_rx_eop = e;
        rx.pkt_rx_mod = m; rx.pkt_rx_err = er; rx.pkt_rx_data = d;
        cyc();
        rx.pkt_rx_val = 0; rx.pkt_rx_sop = 0; rx.pkt_rx_eop = 0; rx.pkt_rx_err = 0;
    endtask

    task automatic pkt(logic [63:0] base, int n, logic [2:0] m, bit er);
        for (int k = 0; k < n; k++)
            word(k == 0, k == n - 1, m, er && (k == n - 1), base + 64'(k));
    endtask

    task automatic do_reset();
        reset_156m25 = 1;
        idle(1);
        reset_156m25 = 0;
    endtask

    task automatic rand_ctl();
        chk_enable      = ($urandom_range(0, 7) != 0);
        rx.pkt_rx_avail = ($urandom_range(0, 3) != 0);
        cnt_clear       = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        int n, cut;
        logic [63:0] b, d;
        logic [2:0]  m;
        bit          er;

        reset_156m25 = 1; chk_enable = 0; cnt_clear = 0; cfg_max_len = 14'd1518;
        rx.pkt_rx_avail = 0; rx.pkt_rx_data = 0; rx.pkt_rx_val = 0; rx.pkt_rx_sop = 0;
        rx.pkt_rx_eop = 0; rx.pkt_rx_err = 0; rx.pkt_rx_mod = 0;
        idle(2);
        reset_156m25 = 0;
        idle(1);
        check("reset pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("reset ren", 64'(rx.pkt_rx_ren), 64'd0);

        // good 64-byte packet
        pkt(64'h0000_0000_0000_0100, 8, 3'd0, 0);
        check("good64 pkt_done", 64'(pkt_done), 64'd1);
        check("good64 pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("good64 byte_cnt", 64'(byte_cnt), 64'd64);
        check("good64 errs", 64'(data_err_cnt | len_err_cnt | frame_err_cnt | mac_err_cnt), 64'd0);
        idle(1);
        check("good64 done pulse", 64'(pkt_done), 64'd0);

        // 65-byte packet: word 8 from base 0 has byte 0 = 0x00, bytes 1..7 are junk
        do_reset();
        for (int k = 0; k < 8; k++) word(k == 0, 0, 3'd1, 0, 64'(k));
        word(0, 1, 3'd1, 0, 64'h00A5_A5A5_A5A5_A5A5);
        check("len65 byte_cnt", 64'(byte_cnt), 64'd65);
        check("len65 data_err", 64'(data_err_cnt), 64'd0);
        for (int k = 0; k < 8; k++) word(k == 0, 0, 3'd1, 0, 64'(k));
        word(0, 1, 3'd1, 0, 64'hFFA5_A5A5_A5A5_A5A5);
        check("len65 flip data_err", 64'(data_err_cnt), 64'd1);

        // wrap and multiple bad words
        do_reset();
        pkt(64'hFFFF_FFFF_FFFF_FFFE, 8, 3'd0, 0);
        check("wrap data_err", 64'(data_err_cnt), 64'd0);
        for (int k = 0; k < 8; k++)
            word(k == 0, k == 7, 3'd0, 0, (64'h10 + 64'(k)) ^ ((k == 2 || k == 5) ? 64'h1 : 64'h0));
        check("two bad words", 64'(data_err_cnt), 64'd1);

        // framing, length, mac error
        do_reset();
        word(1, 0, 3'd0, 0, 64'h200);
        word(0, 0, 3'd0, 0, 64'h201);
        pkt(64'h300, 8, 3'd0, 0);
        check("dbl sop frame_err", 64'(frame_err_cnt), 64'd1);
        check("dbl sop pkt_cnt", 64'(pkt_cnt), 64'd1);
        pkt(64'h0, 4, 3'd0, 0);
        check("short len_err", 64'(len_err_cnt), 64'd1);
        do_reset();
        pkt(64'h0, 190, 3'd7, 0);
        check("1519 len_err", 64'(len_err_cnt), 64'd1);
        check("1519 byte_cnt", 64'(byte_cnt), 64'd1519);
        pkt(64'h0, 190, 3'd6, 0);
        check("1518 len_err", 64'(len_err_cnt), 64'd1);
        pkt(64'h40, 8, 3'd0, 1);
        check("mac_err", 64'(mac_err_cnt), 64'd1);

        // read FSM: chk_enable dropped mid-packet
        do_reset();
        chk_enable = 1; rx.pkt_rx_avail = 1;
        idle(1);
        check("ren start", 64'(rx.pkt_rx_ren), 64'd1);
        word(1, 0, 3'd0, 0, 64'h0);
        chk_enable = 0;
        for (int k = 1; k < 7; k++) word(0, 0, 3'd0, 0, 64'(k));
        check("ren held", 64'(rx.pkt_rx_ren), 64'd1);
        word(0, 1, 3'd0, 0, 64'd7);
        check("ren after eop", 64'(rx.pkt_rx_ren), 64'd0);

        // reset mid-packet, then stray words, then clear with eop
        chk_enable = 1;
        word(1, 0, 3'd0, 0, 64'h900);
        word(0, 0, 3'd0, 0, 64'h901);
        reset_156m25 = 1;
        word(0, 0, 3'd0, 0, 64'h902);
        reset_156m25 = 0;
        check("midrst ren", 64'(rx.pkt_rx_ren), 64'd0);
        check("midrst pkt_cnt", 64'(pkt_cnt), 64'd0);
        word(0, 0, 3'd0, 0, 64'h903);
        word(0, 1, 3'd0, 0, 64'h904);
        check("stray frame_err", 64'(frame_err_cnt), 64'd2);
        pkt(64'h500, 8, 3'd0, 0);
        for (int k = 0; k < 8; k++) begin
            cnt_clear = (k == 7);
            word(k == 0, k == 7, 3'd0, 0, 64'h600 + 64'(k));
        end
        cnt_clear = 0;
        check("clear pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("clear byte_cnt", 64'(byte_cnt), 64'd0);
        check("clear frame_err", 64'(frame_err_cnt), 64'd0);

        // randomized traffic
        do_reset();
        for (int p = 0; p < 300; p++) begin
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 300)) : int'($urandom_range(1, 12));
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5));
            m = 3'($urandom_range(0, 7));
            er = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: cfg_max_len = 14'd1518;
                1: cfg_max_len = 14'd9000;
                2: cfg_max_len = 14'd100;
                default: cfg_max_len = 14'd16383;
            endcase
            if ($urandom_range(0, 15) == 0) begin
                rand_ctl();
                word(0, 1'($urandom_range(0, 1)), 3'd0, 0, {$urandom, $urandom});
            end
            cut = ($urandom_range(0, 12) == 0) ? int'($urandom_range(0, n - 1)) : n;
            for (int k = 0; k < cut; k++) begin
                while ($urandom_range(0, 3) == 0) begin
                    rand_ctl();
                    idle(1);
                end
                d = b + 64'(k);
                if ($urandom_range(0, 30) == 0) d = d ^ (64'd1 << $urandom_range(0, 63));
                rand_ctl();
                word(k == 0, k == n - 1, m, er && (k == n - 1), d);
            end
            if (cut < n && $urandom_range(0, 1) == 0) begin
                reset_156m25 = 1;
                rand_ctl();
                idle(1);
                reset_156m25 = 0;
            end
        end
        cnt_clear = 0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
